// File: rtl/dma_engineer_arbiter.sv
// Round-robin arbiter that shares one DMA engine among NUM_REQ layer controllers.
// One slot is granted at a time; its beat stream is routed back until end-of-packet.
module dma_engineer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_start_addr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_length,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_dout_en,
  output logic [NUM_REQ-1:0]        req_dout_eop,
  output logic [DATA_W-1:0]         req_dout,
  output logic                      dma_req,
  input  logic                      dma_ack,
  output logic [ADDR_W-1:0]         dma_start_addr,
  output logic [ADDR_W-1:0]         dma_length,
  input  logic                      dma_dout_en,
  input  logic                      dma_dout_eop,
  input  logic [DATA_W-1:0]         dma_dout,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t            state_r;
  logic [ID_W-1:0]   rr_r;
  logic              found_s;
  logic [ID_W-1:0]   winner_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [ADDR_W-1:0] win_len_s;
  logic [ID_W-1:0]   rr_next_s;
  int                idx;

  // Search for the first requesting slot starting at the round-robin pointer, with wrap.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = {ID_W{1'b0}};
    win_addr_s = {ADDR_W{1'b0}};
    win_len_s  = {ADDR_W{1'b0}};
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_r) + k) % NUM_REQ;
      if (!found_s && req_req[idx]) begin
        found_s    = 1'b1;
        winner_s   = ID_W'(idx);
        win_addr_s = req_start_addr[idx*ADDR_W +: ADDR_W];
        win_len_s  = req_length[idx*ADDR_W +: ADDR_W];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves past the winner so it gets lowest priority next time.
  always_comb begin
    if (winner_s == ID_W'(NUM_REQ - 1)) begin
      rr_next_s = {ID_W{1'b0}};
    end else begin
      rr_next_s = winner_s + ID_W'(1);
    end
  end

  // Arbitration state machine with registered DMA-side request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      rr_r           <= {ID_W{1'b0}};
      dma_req        <= 1'b0;
      dma_start_addr <= {ADDR_W{1'b0}};
      dma_length     <= {ADDR_W{1'b0}};
      grant_id       <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_id       <= winner_s;
            dma_start_addr <= win_addr_s;
            dma_length     <= win_len_s;
            dma_req        <= 1'b1;
            rr_r           <= rr_next_s;
            state_r        <= REQ;
          end
        end
        REQ: begin
          if (dma_ack) begin
            dma_req <= 1'b0;
            state_r <= XFER;
          end
        end
        XFER: begin
          if (dma_dout_en && dma_dout_eop) begin
            state_r <= IDLE;
          end
        end
        default: begin
          dma_req <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Route the accept pulse and beat qualifiers to the granted slot only.
  always_comb begin
    req_ack      = {NUM_REQ{1'b0}};
    req_dout_en  = {NUM_REQ{1'b0}};
    req_dout_eop = {NUM_REQ{1'b0}};
    case (state_r)
      REQ: begin
        req_ack[grant_id] = dma_ack;
      end
      XFER: begin
        req_dout_en[grant_id]  = dma_dout_en;
        req_dout_eop[grant_id] = dma_dout_eop & dma_dout_en;
      end
      default: begin
        req_ack = {NUM_REQ{1'b0}};
      end
    endcase
  end

  assign req_dout = dma_dout;
  assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_dma_engineer_arbiter.sv
// Self-checking bench for dma_engineer_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_dma_engineer_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 512;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_req;
  logic [NUM_REQ*ADDR_W-1:0] req_start_addr;
  logic [NUM_REQ*ADDR_W-1:0] req_length;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_dout_en;
  logic [NUM_REQ-1:0]        req_dout_eop;
  logic [DATA_W-1:0]         req_dout;
  logic                      dma_req;
  logic                      dma_ack;
  logic [ADDR_W-1:0]         dma_start_addr;
  logic [ADDR_W-1:0]         dma_length;
  logic                      dma_dout_en;
  logic                      dma_dout_eop;
  logic [DATA_W-1:0]         dma_dout;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0 idle, 1 waiting for accept, 2 streaming beats.
  int                m_phase;
  int                m_rr;
  int                m_grant;
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] m_len;
  int                dut_grants[$];

  dma_engineer_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_req(req_req), .req_start_addr(req_start_addr), .req_length(req_length),
    .req_ack(req_ack), .req_dout_en(req_dout_en), .req_dout_eop(req_dout_eop),
    .req_dout(req_dout),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_start_addr(dma_start_addr),
    .dma_length(dma_length), .dma_dout_en(dma_dout_en), .dma_dout_eop(dma_dout_eop),
    .dma_dout(dma_dout), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_beat();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rr = 0; m_grant = 0; m_addr = '0; m_len = '0;
  endtask

  // Apply one clock edge's worth of the arbitration rules to the model.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (m_phase == 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int s;
        s = (m_rr + k) % NUM_REQ;
        if (m_phase == 0 && req_req[s]) begin
          m_grant = s;
          m_addr  = req_start_addr[s*ADDR_W +: ADDR_W];
          m_len   = req_length[s*ADDR_W +: ADDR_W];
          m_rr    = (s + 1) % NUM_REQ;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (dma_ack) m_phase = 2;
    end else begin
      if (dma_dout_en && dma_dout_eop) m_phase = 0;
    end
  endtask

  task automatic check_all();
    logic [NUM_REQ-1:0] e_ack, e_en, e_eop;
    e_ack = '0; e_en = '0; e_eop = '0;
    if (m_phase == 1) e_ack[m_grant] = dma_ack;
    if (m_phase == 2) begin
      e_en[m_grant]  = dma_dout_en;
      e_eop[m_grant] = dma_dout_en & dma_dout_eop;
    end
    chk("busy", busy, m_phase != 0);
    chk("dma_req", dma_req, m_phase == 1);
    chk("dma_start_addr", dma_start_addr, m_addr);
    chk("dma_length", dma_length, m_len);
    chk("grant_id", grant_id, m_grant);
    chk("req_ack", req_ack, e_ack);
    chk("req_dout_en", req_dout_en, e_en);
    chk("req_dout_eop", req_dout_eop, e_eop);
    chk("req_dout", req_dout, dma_dout);
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic set_slot(input int s, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l);
    req_start_addr[s*ADDR_W +: ADDR_W] = a;
    req_length[s*ADDR_W +: ADDR_W]     = l;
  endtask

  // One full transaction: arbitration edge, accept after ack_wait cycles, then beats.
  task automatic run_txn(input int ack_wait, input int beats, input logic [NUM_REQ-1:0] req_after);
    tick();
    dut_grants.push_back(int'(grant_id));
    repeat (ack_wait) tick();
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    req_req = req_after;
    for (int b = 0; b < beats; b++) begin
      dma_dout_en  = 1'b1;
      dma_dout_eop = (b == beats - 1);
      dma_dout     = rnd_beat();
      tick();
    end
    dma_dout_en  = 1'b0;
    dma_dout_eop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_req = '0; req_start_addr = '0; req_length = '0;
    dma_ack = 1'b0; dma_dout_en = 1'b0; dma_dout_eop = 1'b0; dma_dout = '0;
    do_reset();
    tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_gid", grant_id, 2'd0);

    // Single request on slot 0, accept on the third REQ cycle, two beats.
    set_slot(0, 27'h100, 27'd2);
    req_req = 4'b0001;
    tick();
    chk("t1_dma_req", dma_req, 1'b1);
    chk("t1_addr", dma_start_addr, 27'h100);
    chk("t1_len", dma_length, 27'd2);
    tick(); tick();
    dma_ack = 1'b1;
    @(negedge clk);
    chk("t1_ack", req_ack, 4'b0001);
    @(posedge clk); model_step(); #1;
    dma_ack = 1'b0; req_req = 4'b0000;
    dma_dout_en = 1'b1; dma_dout = rnd_beat();
    tick();
    dma_dout_eop = 1'b1; dma_dout = rnd_beat();
    @(negedge clk);
    chk("t1_eop", req_dout_eop, 4'b0001);
    @(posedge clk); model_step(); #1;
    dma_dout_en = 1'b0; dma_dout_eop = 1'b0;
    chk("t1_idle", busy, 1'b0);

    // Round robin with all slots held.
    do_reset();
    for (int s = 0; s < NUM_REQ; s++) set_slot(s, ADDR_W'(s * 16), ADDR_W'(s));
    dut_grants.delete();
    req_req = 4'b1111;
    repeat (5) run_txn(0, 1, 4'b1111);
    req_req = 4'b0000;
    tick();
    chk("rr_count", dut_grants.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), dut_grants[i], i % NUM_REQ);

    // Priority rotation after slot 2 wins.
    do_reset();
    dut_grants.delete();
    req_req = 4'b0100; run_txn(1, 2, 4'b0000);
    req_req = 4'b0101; run_txn(0, 1, 4'b0100);
    run_txn(0, 1, 4'b0000);
    chk("rot_g0", dut_grants[0], 2);
    chk("rot_g1", dut_grants[1], 0);
    chk("rot_g2", dut_grants[2], 2);

    // Stray handshakes while idle and beats while waiting for accept.
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    dma_dout_en = 1'b1; dma_dout_eop = 1'b1; tick();
    dma_dout_eop = 1'b0;
    req_req = 4'b0001; tick();
    dma_dout_en = 1'b1; tick();
    chk("stray_en", req_dout_en, 4'b0000);
    chk("stray_busy", busy, 1'b1);
    dma_dout_en = 1'b0;
    dma_ack = 1'b1; tick(); dma_ack = 1'b0; req_req = 4'b0000;
    dma_dout_en = 1'b1; dma_dout_eop = 1'b1; tick();
    dma_dout_en = 1'b0; dma_dout_eop = 1'b0;

    // Address change while the grant is pending must not leak through.
    do_reset();
    set_slot(1, 27'h40, 27'd1);
    req_req = 4'b0010; tick();
    set_slot(1, 27'h80, 27'd1); tick();
    chk("hold_addr", dma_start_addr, 27'h40);
    dma_ack = 1'b1; tick(); dma_ack = 1'b0; req_req = 4'b0000;
    dma_dout_en = 1'b1; dma_dout_eop = 1'b1; tick();
    dma_dout_en = 1'b0; dma_dout_eop = 1'b0;

    // Reset during beat 3 of an 8-beat transfer.
    req_req = 4'b0100; tick();
    dma_ack = 1'b1; tick(); dma_ack = 1'b0; req_req = 4'b0000;
    dma_dout_en = 1'b1;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int b = 3; b < 8; b++) begin
      dma_dout_eop = (b == 7); dma_dout = rnd_beat(); tick();
      chk("rst_dropped", req_dout_en, 4'b0000);
    end
    dma_dout_en = 1'b0; dma_dout_eop = 1'b0;
    dut_grants.delete();
    req_req = 4'b0010; run_txn(0, 1, 4'b0000);
    chk("rst_regrant", dut_grants[0], 1);

    // Random traffic, including stray handshakes and occasional resets.
    for (int c = 0; c < 2000; c++) begin
      rst          = ($urandom_range(0, 63) == 0);
      req_req      = NUM_REQ'($urandom);
      dma_ack      = $urandom_range(0, 3) == 0;
      dma_dout_en  = $urandom_range(0, 1) == 1;
      dma_dout_eop = $urandom_range(0, 3) == 0;
      dma_dout     = rnd_beat();
      for (int s = 0; s < NUM_REQ; s++) set_slot(s, ADDR_W'($urandom), ADDR_W'($urandom));
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dma_engineer_arbiter.md
Name: dma_engineer_arbiter

Overview:
Round-robin arbiter that shares one DMA engine (weight-fetch port) among NUM_REQ layer controllers. Each layer's dma_engineer_req/ack/start_addr/length/dout_en/dout_eop bundle connects to one requester slot. The arbiter grants one slot at a time, forwards its address/length to the DMA engine, and routes the returned beat stream back to that slot until end-of-packet. Sits between the per-layer controller_v2 instances and the single DMA engine.

Parameters:
NUM_REQ, 4, number of requester slots (2..8)
ID_W, 2, width of grant index, ceil(log2(NUM_REQ))
ADDR_W, 27, start-address and length width
DATA_W, 512, DMA beat width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_req  in  NUM_REQ  per-slot request, held high until that slot's ack
req_start_addr  in  NUM_REQ*ADDR_W  per-slot start address, slot i at [i*ADDR_W +: ADDR_W]
req_length  in  NUM_REQ*ADDR_W  per-slot length, same packing
req_ack  out  NUM_REQ  per-slot one-cycle acknowledge
req_dout_en  out  NUM_REQ  per-slot beat valid
req_dout_eop  out  NUM_REQ  per-slot last beat
req_dout  out  DATA_W  beat data, broadcast to all slots
dma_req  out  1  request to DMA engine
dma_ack  in  1  DMA engine one-cycle accept
dma_start_addr  out  ADDR_W  granted start address
dma_length  out  ADDR_W  granted length
dma_dout_en  in  1  beat valid from DMA engine
dma_dout_eop  in  1  last beat, coincident with dma_dout_en
dma_dout  in  DATA_W  beat data
busy  out  1  high in REQ or XFER
grant_id  out  ID_W  index of current/last granted slot

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. On reset: state IDLE, rr pointer 0, dma_req 0, dma_start_addr 0, dma_length 0, grant_id 0, busy 0; all req_ack/req_dout_en/req_dout_eop 0.
- States: IDLE, REQ, XFER.
- IDLE: if any req_req bit set, pick first set bit searching from rr pointer upward with wrap (rr, rr+1, ..., NUM_REQ-1, 0, ...). On that edge: grant_id <= winner; dma_start_addr/dma_length <= winner's fields; dma_req <= 1; rr <= winner+1 mod NUM_REQ; state <= REQ. No request: stay IDLE, all registers hold.
- Latency: req_req seen high at edge t -> dma_req high from cycle t+1.
- REQ: dma_req held high; address/length registers frozen (later changes on req_* inputs ignored). When dma_ack=1: req_ack[grant_id]=1 in the same cycle (combinational, gated by state==REQ); on that edge dma_req <= 0, state <= XFER. Only one req_ack bit ever high.
- XFER: req_dout_en[grant_id]=dma_dout_en, req_dout_eop[grant_id]=dma_dout_eop&dma_dout_en, combinational; other slots 0. On edge with dma_dout_en&dma_dout_eop: state <= IDLE. Earliest next grant: dma_req high two cycles after the eop beat.
- req_dout = dma_dout at all times (qualified only by req_dout_en).
- dma_ack outside REQ ignored. dma_dout_en/eop outside XFER ignored, never routed. dma_dout_eop without dma_dout_en ignored.
- Requester dropping req_req while in REQ/XFER: ignored; transaction completes to eop.
- Granted slot re-requesting immediately: it has lowest priority at next arbitration (rr already advanced).
- dma_length = 0 forwarded unchanged; arbiter still waits for eop.
- busy = (state != IDLE). grant_id holds after return to IDLE.
- Reset mid-REQ/XFER: returns to IDLE with reset values next cycle; in-flight beats dropped.
- No buffering: beats pass through with zero latency; backpressure not supported.

Test Plan:
- Single request: reset, req_req=0001, addr slot0=0x100, len=2; dma_ack at cycle 3, two beats with eop on 2nd -> dma_req high cycles 1..3, dma_start_addr=0x100, dma_length=2, req_ack=0001 at cycle 3, req_dout_en[0] on both beats, req_dout_eop[0] on beat 2, busy low after eop.
- Round robin: req_req=1111 held, each transfer 1 beat -> grant order 0,1,2,3,0; each slot's req_ack exactly once per grant.
- Priority rotation: slot2 granted, then req_req=0101 -> grant slot 0 after... rr=3, search 3,0 -> grant 0; then req_req=0100 -> grant 2.
- Stray signals: dma_ack and dma_dout_en pulses while IDLE, dma_dout_en during REQ -> no req_ack, no req_dout_en, state unchanged.
- Input change during hold: slot1 changes start_addr 0x40->0x80 while REQ -> dma_start_addr stays 0x40 until next grant.
- Reset mid-XFER: rst during beat 3 of 8 -> next cycle all outputs zero, subsequent beats not routed; new req_req=0010 granted with rr restarted at 0.
